// File: rtl/consec_run_pkg.sv
// Shared types and helpers for the consecutive-run counter.
// Optional feature macro used by the top: CONSEC_RUN_STICKY_EN.
package consec_run_pkg;

  localparam logic POL_ZEROS = 1'b0;
  localparam logic POL_ONES  = 1'b1;

  // What the next-state logic decided this cycle; exported for debug.
  typedef enum logic [2:0] {
    ACT_HOLD  = 3'd0,
    ACT_CLEAR = 3'd1,
    ACT_BREAK = 3'd2,
    ACT_INC   = 3'd3,
    ACT_SAT   = 3'd4
  } run_action_e;

  function automatic int count_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/consec_run_if.sv
// Sample/run-status bundle between the input sampler (master) and the run counter (slave).
// Handshake: valid qualifies w/polarity in the same cycle; there is no ready, the counter accepts every valid sample.
interface consec_run_if #(
  parameter int CW = 3
);
  logic          valid;
  logic          w;
  logic          polarity;
  logic          clear;
  logic [CW-1:0] count;
  logic          z;
  logic          sat;
  logic          hit;

  modport master (
    output valid, w, polarity, clear,
    input  count, z, sat, hit
  );

  modport slave (
    input  valid, w, polarity, clear,
    output count, z, sat, hit
  );
endinterface

// File: rtl/consec_run_next_state.sv
// Pure combinational next-count function: clear > valid, saturating increment on match, zero on mismatch.
import consec_run_pkg::*;

module consec_run_next_state #(
  parameter int MAX_COUNT = 4,
  parameter int CW        = 3
) (
  input  logic [CW-1:0] i_count,
  input  logic          i_valid,
  input  logic          i_w,
  input  logic          i_polarity,
  input  logic          i_clear,
  output logic [CW-1:0] o_count_next,
  output run_action_e   o_action
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  always_comb begin
    o_count_next = i_count;
    o_action     = ACT_HOLD;
    if (i_clear) begin
      o_count_next = '0;
      o_action     = ACT_CLEAR;
    end else if (i_valid) begin
      if (i_w == i_polarity) begin
        // Saturate rather than wrap once the run is at its ceiling.
        if (i_count >= MAX_C) begin
          o_count_next = MAX_C;
          o_action     = ACT_SAT;
        end else begin
          o_count_next = i_count + ONE_C;
          o_action     = ACT_INC;
        end
      end else begin
        o_count_next = '0;
        o_action     = ACT_BREAK;
      end
    end
  end

endmodule

// File: rtl/consec_run_counter.sv
// Consecutive-run detector: registered run length with threshold, saturation and hit outputs.
// Define CONSEC_RUN_STICKY_EN to make hit a sticky flag held until clear/reset.
import consec_run_pkg::*;

module consec_run_counter #(
  parameter int MAX_COUNT = 4,
  parameter int THRESH    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  consec_run_if.slave   io_bus,
  output run_action_e   o_dbg_action
);

  localparam int CW = count_width(MAX_COUNT);
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_COUNT);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  if (MAX_COUNT < 1) begin : g_bad_max
    $error("consec_run_counter: MAX_COUNT must be >= 1");
  end
  if (THRESH < 1) begin : g_bad_thresh_lo
    $error("consec_run_counter: THRESH must be >= 1");
  end
  if (THRESH > MAX_COUNT) begin : g_bad_thresh_hi
    $error("consec_run_counter: THRESH must be <= MAX_COUNT");
  end

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          w_z;
  logic          w_sat;

  consec_run_next_state #(
    .MAX_COUNT (MAX_COUNT),
    .CW        (CW)
  ) u_next (
    .i_count      (r_count),
    .i_valid      (io_bus.valid),
    .i_w          (io_bus.w),
    .i_polarity   (io_bus.polarity),
    .i_clear      (io_bus.clear),
    .o_count_next (w_count_next),
    .o_action     (o_dbg_action)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  // Moore decodes straight off the count register.
  assign w_z   = (r_count >= THRESH_C);
  assign w_sat = (r_count == MAX_C);

  assign io_bus.count = r_count;
  assign io_bus.z     = w_z;
  assign io_bus.sat   = w_sat;

`ifdef CONSEC_RUN_STICKY_EN
  logic r_hit;

  // Clear already forces the next count to zero, so it also wins over a same-cycle crossing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hit <= 1'b0;
    end else if (io_bus.clear) begin
      r_hit <= 1'b0;
    end else if (w_count_next >= THRESH_C) begin
      r_hit <= 1'b1;
    end
  end

  assign io_bus.hit = r_hit;
`else
  assign io_bus.hit = w_z;
`endif

endmodule

// File: tb/tb_consec_run_counter.sv
// Directed bench for consec_run_counter: vector table on a default instance, hand sequence on a THRESH=2/MAX_COUNT=7 instance.
import consec_run_pkg::*;

module tb_consec_run_counter;

  typedef struct {
    logic rst;
    logic valid;
    logic w;
    logic pol;
    logic clr;
    int   cnt;
    logic z;
    logic sat;
    logic hit_ns;
    logic hit_st;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  run_action_e act_a;
  run_action_e act_b;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  consec_run_if #(.CW(3)) bus_a ();
  consec_run_if #(.CW(3)) bus_b ();

  consec_run_counter #(.MAX_COUNT(4), .THRESH(4)) dut_a (
    .i_clk        (clk),
    .i_rst        (rst_a),
    .io_bus       (bus_a),
    .o_dbg_action (act_a)
  );

  consec_run_counter #(.MAX_COUNT(7), .THRESH(2)) dut_b (
    .i_clk        (clk),
    .i_rst        (rst_b),
    .io_bus       (bus_b),
    .o_dbg_action (act_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic valid, input logic w,
                              input logic pol, input logic clr, input int cnt,
                              input logic z, input logic sat, input logic hit_ns,
                              input logic hit_st);
    vec_t v;
    v.rst = rst; v.valid = valid; v.w = w; v.pol = pol; v.clr = clr;
    v.cnt = cnt; v.z = z; v.sat = sat; v.hit_ns = hit_ns; v.hit_st = hit_st;
    vecs.push_back(v);
  endfunction

  function automatic logic sel_hit(input logic hit_ns, input logic hit_st);
`ifdef CONSEC_RUN_STICKY_EN
    return hit_st;
`else
    return hit_ns;
`endif
  endfunction

  initial begin
    bus_a.valid = 1'b0; bus_a.w = 1'b0; bus_a.polarity = POL_ONES; bus_a.clear = 1'b0;
    bus_b.valid = 1'b0; bus_b.w = 1'b0; bus_b.polarity = POL_ONES; bus_b.clear = 1'b0;

    //   rst v  w  p  c  cnt z  s  hns hst
    // run of ones to saturation
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 2, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 3, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 4, 1, 1, 1, 1);
    add(0, 1, 1, 1, 0, 4, 1, 1, 1, 1);
    add(0, 1, 1, 1, 0, 4, 1, 1, 1, 1);
    // break the run: hit follows z or sticks; clear drops it
    add(0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    // mismatch mid-run, ones polarity
    add(0, 1, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 2, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 1, 0, 0, 0, 0);
    // same trace with zeros polarity and inverted input
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 2, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    // valid gaps hold the run
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 2, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 2, 0, 0, 0, 0);
    // clear beats a matching sample; reset beats everything
    add(0, 1, 1, 1, 0, 3, 0, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 2, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 3, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    // polarity switch mid-run: no implicit clear
    add(0, 1, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 2, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 3, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // clear on the cycle that would cross the threshold
    add(0, 1, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 2, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 3, 0, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 1, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      rst_a          = vecs[i].rst;
      bus_a.valid    = vecs[i].valid;
      bus_a.w        = vecs[i].w;
      bus_a.polarity = vecs[i].pol;
      bus_a.clear    = vecs[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d count", i), int'(bus_a.count), vecs[i].cnt);
      chk($sformatf("vec%0d z", i), int'(bus_a.z), int'(vecs[i].z));
      chk($sformatf("vec%0d sat", i), int'(bus_a.sat), int'(vecs[i].sat));
      chk($sformatf("vec%0d hit", i), int'(bus_a.hit),
          int'(sel_hit(vecs[i].hit_ns, vecs[i].hit_st)));
    end
    rst_a = 1'b0;
    bus_a.valid = 1'b0;
    bus_a.clear = 1'b0;

    // THRESH=2, MAX_COUNT=7 instance: nine matching samples, then a break and a clear
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    chk("b reset count", int'(bus_b.count), 0);
    chk("b reset z", int'(bus_b.z), 0);
    chk("b reset hit", int'(bus_b.hit), 0);
    rst_b = 1'b0;
    bus_b.polarity = POL_ONES;
    bus_b.valid = 1'b1;
    bus_b.w = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("b edge%0d count", k), int'(bus_b.count), (k < 7) ? k : 7);
      chk($sformatf("b edge%0d z", k), int'(bus_b.z), (k >= 2) ? 1 : 0);
      chk($sformatf("b edge%0d sat", k), int'(bus_b.sat), (k >= 7) ? 1 : 0);
      chk($sformatf("b edge%0d hit", k), int'(bus_b.hit), (k >= 2) ? 1 : 0);
    end
    bus_b.w = 1'b0;
    @(posedge clk);
    #1;
    chk("b break count", int'(bus_b.count), 0);
    chk("b break z", int'(bus_b.z), 0);
    chk("b break sat", int'(bus_b.sat), 0);
    chk("b break hit", int'(bus_b.hit), int'(sel_hit(1'b0, 1'b1)));
    bus_b.valid = 1'b0;
    bus_b.clear = 1'b1;
    @(posedge clk);
    #1;
    chk("b clear hit", int'(bus_b.hit), 0);
    chk("b clear action", int'(act_b), int'(ACT_CLEAR));
    bus_b.clear = 1'b0;
    #1;
    chk("b idle action", int'(act_b), int'(ACT_HOLD));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
